// File: rtl/matrix_frame_loader_if.sv
// Serial input and display-side outputs of the matrix frame loader.
// The master side drives the UART line and observes the frame; the slave side is the loader.
interface matrix_frame_loader_if;
   logic        serial_rx;
   logic [63:0] frame;
   logic        frame_update;
   logic        err_checksum;
   logic        err_framing;
   logic        busy;

   modport master (
      output serial_rx,
      input  frame, frame_update, err_checksum, err_framing, busy
   );

   modport slave (
      input  serial_rx,
      output frame, frame_update, err_checksum, err_framing, busy
   );
endinterface

// File: rtl/matrix_frame_loader.sv
// UART 8N1 receiver plus packet parser for an 8x8 LED picture.
// Packet: SYNC, 8 row bytes (row 0 first), XOR-of-rows checksum.
// Rows are collected in a shadow buffer; the visible frame is only
// replaced when a complete packet with a matching checksum arrives.
module matrix_frame_loader #(
   parameter int         CLK_HZ       = 50_000_000,
   parameter int         BAUD         = 115200,
   parameter int         TIMEOUT_BITS = 40,
   parameter logic [7:0] SYNC         = 8'hA5
) (
   input logic                  clkI,
   input logic                  rstnI,
   matrix_frame_loader_if.slave bus
);

   localparam int DIV    = CLK_HZ / BAUD;
   localparam int HALF   = DIV / 2;
   localparam int CW     = $clog2(DIV) + 1;
   localparam int TO_MAX = TIMEOUT_BITS * DIV;
   localparam int TW     = $clog2(TO_MAX + 1);

   // The counter acts on the cycle it sits at zero, so loading N-1 gives a
   // period of exactly N clocks between samples.
   localparam logic [CW-1:0] HALF_LD  = CW'(HALF - 1);
   localparam logic [CW-1:0] DIV_LD   = CW'(DIV - 1);
   localparam logic [TW-1:0] TO_LIMIT = TW'(TO_MAX);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {P_HUNT, P_ROW, P_CHK} p_state_t;

   // ---------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------
   logic sync1_q, sync2_q, rx_prev_q;
   logic rx_s, rx_fall;

   // Two-flop synchronizer plus one history flop for falling-edge detection; idle-high preset.
   always_ff @(posedge clkI or negedge rstnI) begin
      if (!rstnI) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= bus.serial_rx;
         sync2_q   <= sync1_q;
         rx_prev_q <= sync2_q;
      end
   end

   assign rx_s    = sync2_q;
   assign rx_fall = rx_prev_q & ~rx_s;

   // ---------------------------------------------------------------
   // UART receive FSM
   // ---------------------------------------------------------------
   rx_state_t       rx_state_q, rx_state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            byte_valid, byte_bad;

   // RX state, bit timer, bit index and assembled byte.
   always_ff @(posedge clkI or negedge rstnI) begin
      if (!rstnI) begin
         rx_state_q <= RX_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
      end
   end

   // RX next state: centre the start bit with HALF, then sample every DIV clocks.
   always_comb begin
      rx_state_d = rx_state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      byte_valid = 1'b0;
      byte_bad   = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_fall) begin
               cnt_d      = HALF_LD;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (cnt_q == '0) begin
               if (rx_s) begin
                  // Line went high again before mid start bit: glitch.
                  rx_state_d = RX_IDLE;
               end else begin
                  cnt_d      = DIV_LD;
                  idx_d      = 3'd0;
                  rx_state_d = RX_DATA;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RX_DATA: begin
            if (cnt_q == '0) begin
               shift_d[idx_q] = rx_s;
               cnt_d          = DIV_LD;
               if (idx_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RX_STOP: begin
            if (cnt_q == '0) begin
               if (rx_s) begin
                  byte_valid = 1'b1;
               end else begin
                  byte_bad = 1'b1;
               end
               // Leave at mid stop bit so a back-to-back start edge is caught.
               rx_state_d = RX_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Shadow buffer: one register per row, written in packet order
   // ---------------------------------------------------------------
   p_state_t    p_state_q, p_state_d;
   logic [2:0]  row_q, row_d;
   logic [63:0] shadow_flat;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_row
         logic [7:0] shadow_q;
         logic       row_we;

         assign row_we = byte_valid && (p_state_q == P_ROW) && (row_q == 3'(gi));

         // Capture this row's byte while the parser is filling row gi.
         always_ff @(posedge clkI or negedge rstnI) begin
            if (!rstnI) begin
               shadow_q <= '0;
            end else if (row_we) begin
               shadow_q <= shift_q;
            end
         end

         assign shadow_flat[63-8*gi -: 8] = shadow_q;
      end
   endgenerate

   // ---------------------------------------------------------------
   // Packet parser
   // ---------------------------------------------------------------
   logic [7:0]    xor_q, xor_d;
   logic [TW-1:0] idle_q, idle_d;
   logic [63:0]   frame_q, frame_d;
   logic          upd_q, upd_d;
   logic          cks_q, cks_d;
   logic          ferr_q, ferr_d;
   logic          timed_out;

   // Parser state, checksum accumulator, gap timer, visible frame and pulses.
   always_ff @(posedge clkI or negedge rstnI) begin
      if (!rstnI) begin
         p_state_q <= P_HUNT;
         row_q     <= '0;
         xor_q     <= '0;
         idle_q    <= '0;
         frame_q   <= '0;
         upd_q     <= 1'b0;
         cks_q     <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         p_state_q <= p_state_d;
         row_q     <= row_d;
         xor_q     <= xor_d;
         idle_q    <= idle_d;
         frame_q   <= frame_d;
         upd_q     <= upd_d;
         cks_q     <= cks_d;
         ferr_q    <= ferr_d;
      end
   end

   assign timed_out = (idle_q == TO_LIMIT);

   // Parser next state; a received byte always takes priority over the gap timeout.
   always_comb begin
      p_state_d = p_state_q;
      row_d     = row_q;
      xor_d     = xor_q;
      idle_d    = idle_q;
      frame_d   = frame_q;
      upd_d     = 1'b0;
      cks_d     = 1'b0;
      ferr_d    = byte_bad;

      // Gap timer: only meaningful inside a packet, saturates at the limit.
      if (p_state_q == P_HUNT || byte_valid) begin
         idle_d = '0;
      end else if (rx_state_q == RX_IDLE && !timed_out) begin
         idle_d = idle_q + TW'(1);
      end

      case (p_state_q)
         P_HUNT: begin
            if (byte_valid && shift_q == SYNC) begin
               p_state_d = P_ROW;
               row_d     = 3'd0;
               xor_d     = 8'h00;
            end
         end
         P_ROW: begin
            if (byte_valid) begin
               xor_d = xor_q ^ shift_q;
               row_d = row_q + 3'd1;
               if (row_q == 3'd7) begin
                  p_state_d = P_CHK;
               end
            end else if (byte_bad || timed_out) begin
               p_state_d = P_HUNT;
            end
         end
         P_CHK: begin
            if (byte_valid) begin
               if (shift_q == xor_q) begin
                  frame_d = shadow_flat;
                  upd_d   = 1'b1;
               end else begin
                  cks_d = 1'b1;
               end
               p_state_d = P_HUNT;
            end else if (byte_bad || timed_out) begin
               p_state_d = P_HUNT;
            end
         end
         default: p_state_d = P_HUNT;
      endcase
   end

   assign bus.frame        = frame_q;
   assign bus.frame_update = upd_q;
   assign bus.err_checksum = cks_q;
   assign bus.err_framing  = ferr_q;
   assign bus.busy         = (p_state_q != P_HUNT);

endmodule

// File: tb/tb_matrix_frame_loader.sv
// Bench for matrix_frame_loader: directed vector table, hand-written
// corner sequences (glitch, gap timeout, async reset) and random packets
// checked against a packet-level model of the displayed frame.
module tb_matrix_frame_loader;

   localparam int CLK_HZ       = 1_000_000;
   localparam int BAUD         = 100_000;
   localparam int DIV          = CLK_HZ / BAUD;
   localparam int HALF         = DIV / 2;
   localparam int TIMEOUT_BITS = 40;
   // Start-bit line edge to visible frame: 2 synchronizer flops, 1 clock to
   // see the edge, HALF to the start-bit centre, 9 bit periods to the stop-bit centre.
   localparam int UPD_LAT      = 3 + HALF + 9 * DIV;

   localparam logic [63:0] PIC_P = 64'h000C0EFFFF0E0C88;
   localparam logic [63:0] PIC_Q = 64'h8142241818244281;

   typedef struct {
      logic [63:0] rows;
      bit          garbage;
      logic [7:0]  chk_flip;
      int          ferr_at;
      logic [63:0] exp_frame;
      int          exp_upd;
      int          exp_cks;
      int          exp_ferr;
   } vec_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   matrix_frame_loader_if bus_if ();

   matrix_frame_loader #(
      .CLK_HZ      (CLK_HZ),
      .BAUD        (BAUD),
      .TIMEOUT_BITS(TIMEOUT_BITS),
      .SYNC        (8'hA5)
   ) dut (
      .clkI (clk),
      .rstnI(rstn),
      .bus  (bus_if)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor sampled on the falling edge.
   int          n_upd = 0, n_cks = 0, n_ferr = 0, n_both = 0, n_stray = 0;
   int          last_upd_cyc = -1;
   logic [63:0] prev_frame = '0;
   always @(negedge clk) begin
      if (bus_if.frame_update) begin
         n_upd        <= n_upd + 1;
         last_upd_cyc <= cyc;
      end
      if (bus_if.err_checksum) n_cks  <= n_cks + 1;
      if (bus_if.err_framing)  n_ferr <= n_ferr + 1;
      if (bus_if.frame_update && bus_if.err_checksum) n_both <= n_both + 1;
      if (rstn && bus_if.frame !== prev_frame && !bus_if.frame_update) n_stray <= n_stray + 1;
      prev_frame <= bus_if.frame;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s %s: got %0h, expected %0h", tag, name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_hi);
      bus_if.serial_rx = 1'b0;
      wait_clks(DIV);
      for (int i = 0; i < 8; i++) begin
         bus_if.serial_rx = b[i];
         wait_clks(DIV);
      end
      bus_if.serial_rx = stop_hi;
      wait_clks(DIV);
      bus_if.serial_rx = 1'b1;
   endtask

   // Sends optional garbage, SYNC, 8 rows and checksum; a framing error at
   // byte index ferr_at (0 = SYNC) abandons the rest of the packet.
   task automatic send_packet(input logic [63:0] rows, input bit garbage, input logic [7:0] chk_flip,
                              input int ferr_at, output int chk_start);
      logic [7:0] pkt [10];
      logic [7:0] chk;
      chk    = 8'h00;
      pkt[0] = 8'hA5;
      for (int r = 0; r < 8; r++) begin
         pkt[r+1] = rows[63-8*r -: 8];
         chk      = chk ^ pkt[r+1];
      end
      pkt[9]    = chk ^ chk_flip;
      chk_start = -1;
      if (garbage) begin
         send_byte(8'h00, 1'b1);
         send_byte(8'hFF, 1'b1);
         send_byte(8'h3C, 1'b1);
      end
      for (int i = 0; i < 10; i++) begin
         if (i == 9) chk_start = cyc;
         if (i == ferr_at) begin
            send_byte(pkt[i], 1'b0);
            break;
         end
         send_byte(pkt[i], 1'b1);
      end
      wait_clks(3 * DIV);
   endtask

   task automatic apply(input string tag, input vec_t v);
      int u0, c0, f0, cs;
      u0 = n_upd; c0 = n_cks; f0 = n_ferr;
      send_packet(v.rows, v.garbage, v.chk_flip, v.ferr_at, cs);
      $display("%s: rows=%h garbage=%0d flip=%h ferr_at=%0d -> frame=%h", tag, v.rows, v.garbage,
               v.chk_flip, v.ferr_at, bus_if.frame);
      check(tag, "frame", bus_if.frame, v.exp_frame);
      check(tag, "frame_update count", 64'(n_upd - u0), 64'(v.exp_upd));
      check(tag, "err_checksum count", 64'(n_cks - c0), 64'(v.exp_cks));
      check(tag, "err_framing count", 64'(n_ferr - f0), 64'(v.exp_ferr));
      check(tag, "busy idle", 64'(bus_if.busy), 64'(0));
      if (v.exp_upd == 1) check(tag, "update latency", 64'(last_upd_cyc - cs), 64'(UPD_LAT));
   endtask

   vec_t        tbl [6];
   vec_t        rv;
   logic [63:0] model_frame;
   int          u0, c0, f0, kind;

   initial begin
      bus_if.serial_rx = 1'b1;

      // {rows, garbage, chk_flip, ferr_at, exp_frame, exp_upd, exp_cks, exp_ferr}
      tbl[0] = '{PIC_P, 1'b0, 8'h00, -1, PIC_P, 1, 0, 0};
      tbl[1] = '{PIC_P, 1'b0, 8'hFF, -1, PIC_P, 0, 1, 0};
      tbl[2] = '{PIC_Q, 1'b0, 8'hFF, -1, PIC_P, 0, 1, 0};
      tbl[3] = '{PIC_Q, 1'b0, 8'h00,  4, PIC_P, 0, 0, 1};
      tbl[4] = '{PIC_Q, 1'b0, 8'h00, -1, PIC_Q, 1, 0, 0};
      tbl[5] = '{PIC_P, 1'b1, 8'h00, -1, PIC_P, 1, 0, 0};

      wait_clks(3);
      check("reset", "frame", bus_if.frame, 64'h0);
      check("reset", "busy", 64'(bus_if.busy), 64'(0));
      check("reset", "pulses", {61'h0, bus_if.frame_update, bus_if.err_checksum, bus_if.err_framing}, 64'h0);
      rstn = 1'b1;
      wait_clks(2 * DIV);

      for (int i = 0; i < 6; i++) apply($sformatf("vec%0d", i), tbl[i]);
      model_frame = PIC_P;

      // Short low glitch on an idle line: no byte, no pulse.
      u0 = n_upd; c0 = n_cks; f0 = n_ferr;
      bus_if.serial_rx = 1'b0;
      wait_clks(4 * DIV / 10);
      bus_if.serial_rx = 1'b1;
      wait_clks(3 * DIV);
      $display("glitch: frame=%h", bus_if.frame);
      check("glitch", "pulse count", 64'((n_upd - u0) + (n_cks - c0) + (n_ferr - f0)), 64'(0));
      check("glitch", "frame", bus_if.frame, model_frame);

      // Packet stalled after row 4 for 41 bit times.
      u0 = n_upd; c0 = n_cks; f0 = n_ferr;
      send_byte(8'hA5, 1'b1);
      for (int r = 0; r < 5; r++) send_byte(PIC_Q[63-8*r -: 8], 1'b1);
      wait_clks(35 * DIV);
      check("stall", "busy before timeout", 64'(bus_if.busy), 64'(1));
      wait_clks(6 * DIV);
      $display("stall: busy=%0d frame=%h", bus_if.busy, bus_if.frame);
      check("stall", "busy after timeout", 64'(bus_if.busy), 64'(0));
      check("stall", "pulse count", 64'((n_upd - u0) + (n_cks - c0) + (n_ferr - f0)), 64'(0));
      check("stall", "frame", bus_if.frame, model_frame);
      rv = '{PIC_Q, 1'b0, 8'h00, -1, PIC_Q, 1, 0, 0};
      apply("after_stall", rv);
      model_frame = PIC_Q;

      // Asynchronous reset in the middle of row 6.
      send_byte(8'hA5, 1'b1);
      for (int r = 0; r < 6; r++) send_byte(PIC_P[63-8*r -: 8], 1'b1);
      bus_if.serial_rx = 1'b0;
      wait_clks(DIV);
      for (int i = 0; i < 3; i++) begin
         bus_if.serial_rx = PIC_P[15-8*0 - 8 + i];
         wait_clks(DIV);
      end
      #2;
      rstn = 1'b0;
      #1;
      $display("async reset: frame=%h busy=%0d", bus_if.frame, bus_if.busy);
      check("async_reset", "frame", bus_if.frame, 64'h0);
      check("async_reset", "busy", 64'(bus_if.busy), 64'(0));
      check("async_reset", "pulses", {61'h0, bus_if.frame_update, bus_if.err_checksum, bus_if.err_framing}, 64'h0);
      bus_if.serial_rx = 1'b1;
      wait_clks(5);
      rstn = 1'b1;
      wait_clks(2 * DIV);
      rv = '{PIC_P, 1'b0, 8'h00, -1, PIC_P, 1, 0, 0};
      apply("after_reset", rv);
      model_frame = PIC_P;

      // Random packets against a packet-level model: the display holds the
      // rows of the last packet whose checksum matched.
      for (int k = 0; k < 12; k++) begin
         kind        = int'($urandom_range(0, 3));
         rv.rows     = {$urandom, $urandom};
         rv.garbage  = (kind == 3);
         rv.chk_flip = 8'h00;
         rv.ferr_at  = -1;
         rv.exp_upd  = 0;
         rv.exp_cks  = 0;
         rv.exp_ferr = 0;
         case (kind)
            1: begin
               rv.chk_flip = 8'($urandom_range(1, 255));
               rv.exp_cks  = 1;
            end
            2: begin
               rv.ferr_at  = int'($urandom_range(0, 9));
               rv.exp_ferr = 1;
            end
            default: begin
               model_frame = rv.rows;
               rv.exp_upd  = 1;
            end
         endcase
         rv.exp_frame = model_frame;
         apply($sformatf("rand%0d", k), rv);
      end

      check("global", "update with checksum error", 64'(n_both), 64'(0));
      check("global", "frame change without update", 64'(n_stray), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/matrix_frame_loader.md
Name: matrix_frame_loader

Overview:
- UART 8N1 receiver plus packet parser that takes a complete 8x8 picture from the expansion board serial line (serial_rx).
- Presents the picture as a double-buffered frame register, which feeds the 8x8 LED matrix scanner's row-data input directly.
- The display frame changes only on a fully received, checksum-correct packet. The scanner therefore never shows a partial image.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate. Derived DIV = CLK_HZ/BAUD (integer, truncated), HALF = DIV/2.
- TIMEOUT_BITS, 40, maximum idle gap inside a packet, in bit times, before the parser abandons the packet.
- SYNC, 8'hA5, packet header byte.

Ports:
- clkI  in  1  system clock, all logic on rising edge.
- rstnI  in  1  asynchronous active-low reset.
- serial_rx  in  1  raw UART line, idle high, asynchronous to clkI.
- frame  out  64  display frame. Row r is frame[63-8r -: 8]. Bit 7 of each row is column 0; 1 = LED on.
- frame_update  out  1  one-cycle pulse, coincident with the first cycle a new frame value is visible.
- err_checksum  out  1  one-cycle pulse, packet rejected on bad checksum.
- err_framing  out  1  one-cycle pulse, stop bit sampled low.
- busy  out  1  high while the parser is past the SYNC byte (state ROW or CHK).

Behaviour:
- Reset (rstnI low, asynchronous): frame=0, all pulses 0, busy=0. Synchronizer flops preset to 1. RX FSM goes to IDLE, parser goes to HUNT, shadow buffer is cleared. Reset asserted mid-packet discards the packet, with no pulse. Release is sampled synchronously (normal flop behaviour).
- Input conditioning: serial_rx passes through a 2-flop synchronizer. rx_s is the second flop output. Edge detection compares rx_s with its previous value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge of rx_s, load the bit counter with HALF, then go to START.
  - START: count down. At zero, if rx_s=1 it is a glitch: return to IDLE silently. Otherwise reload DIV and go to DATA with bit index 0.
  - DATA: at each counter zero, sample rx_s into bit[idx], LSB first, and reload DIV. After idx 7, go to STOP.
  - STOP: at counter zero, if rx_s=1, raise internal byte_valid for exactly one cycle with the byte. If rx_s=0, pulse err_framing and raise byte_bad for one cycle. Either way return to IDLE in the same cycle, which allows back-to-back bytes.
- Parser states: HUNT, ROW, CHK.
  - HUNT: byte_valid with byte==SYNC → ROW, row index 0, xor accumulator 0. Any other byte is ignored.
  - ROW: byte_valid stores the byte into shadow[row], xor ^= byte and row++. After row 7 → CHK.
  - CHK: on byte_valid, if byte == xor of the 8 row bytes, then on the next clock edge frame <= shadow and frame_update=1 for that cycle. Otherwise err_checksum pulses for one cycle and frame is unchanged. Both cases → HUNT.
  - A SYNC value received in ROW/CHK is treated as data; there is no resync.
- Abort conditions: byte_bad in ROW/CHK → HUNT, frame unchanged, no err_checksum. A byte_bad in HUNT only produces the err_framing pulse.
- Gap timeout: in ROW/CHK, an idle counter counts clocks while the RX FSM is in IDLE. It is cleared on every byte_valid. When it reaches TIMEOUT_BITS*DIV, the parser → HUNT with no pulse.
- Latency: frame_update occurs 1 clock after the checksum byte's stop-bit sample cycle.
- Widths:
  - Bit counter width is clog2(DIV)+1.
  - Timeout counter must hold TIMEOUT_BITS*DIV without wrap; it saturates.
  - xor accumulator is 8 bits.
- Simultaneous events: reset overrides everything. A timeout and a byte_valid in the same cycle resolve in favour of byte_valid.
- Pulse exclusivity: err_checksum and frame_update never assert together.

Test Plan:
- Bench parameters: CLK_HZ=1_000_000, BAUD=100_000, so DIV=10.
- Valid packet: A5,00,0C,0E,FF,FF,0E,0C,88, checksum 88^0C^0E^FF^FF^0E^0C^00=88... Compute the checksum in the bench from the row bytes; do not hardcode it. Required: frame=64'h000C0EFFFF0E0C88 and one frame_update pulse, exactly 1 clk after the final stop-bit sample.
- Same packet with the checksum byte inverted: err_checksum pulses once, frame keeps its previous value, no frame_update, busy falls.
- Stop bit forced low on row byte 3: err_framing pulses once, the parser returns to HUNT, frame is unchanged. A following valid packet then loads correctly.
- Garbage bytes 00,FF,3C before A5 plus a valid packet: the garbage is ignored and the frame loads. Separately, a 0.4-bit-time low glitch on an idle line produces no byte and no pulse.
- Packet stalled after row 4 for 41 bit times, then a fresh valid packet: no pulse for the stalled packet and busy drops at the timeout. The fresh packet loads.
- rstnI pulsed low mid-row 6, asynchronously between clock edges: all outputs are 0 immediately. After release, a valid packet loads normally.
